fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of the asynchronous `fifo` among `NREQ` producers. Each producer presents a request and a data word. The arbiter selects one producer at a time, drives a one-cycle `winc` pulse with that producer's word, and returns a per-producer acknowledge. It sits directly in front of the `fifo` write side and runs on the same main clock `clk`.

---
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo write port among NREQ producers; registered outputs, one beat per two cycles.
// Define FIFO_ARB_BURST_EN to let the current owner keep the port for up to MAX_BURST consecutive beats.
module fifo_wr_arbiter #(
  parameter int DSIZE     = 4,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 2,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  input  logic                  fifo_full,
  output logic                  fifo_winc,
  output logic [DSIZE-1:0]      fifo_wdata,
  output logic [IDW-1:0]        gnt_id
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 8 || DSIZE < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] rr_win;
  logic [IDW-1:0] win;
  logic           any_req;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan from the far end back toward ptr so the closest requester wins.
  always_comb begin
    rr_win = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[wrap_add(ptr, i)]) rr_win = wrap_add(ptr, i);
    end
  end

  assign any_req = |req;

`ifdef FIFO_ARB_BURST_EN
  localparam int BCW = $clog2(MAX_BURST + 1);

  logic [BCW-1:0] burst_cnt;
  logic [BCW-1:0] cnt_nxt;
  logic           keep;

  always_comb begin
    keep    = req[gnt_id] && (burst_cnt < BCW'(MAX_BURST));
    win     = keep ? gnt_id : rr_win;
    cnt_nxt = keep ? burst_cnt + BCW'(1) : BCW'(1);
  end
`else
  assign win = rr_win;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      fifo_winc  <= 1'b0;
      fifo_wdata <= '0;
      ack        <= '0;
      gnt_id     <= '0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_full && any_req) begin
            state      <= WRITE;
            fifo_winc  <= 1'b1;
            fifo_wdata <= req_data[int'(win)*DSIZE +: DSIZE];
            ack        <= NREQ'(1) << win;
            gnt_id     <= win;
            // While the owner keeps bursting this rewrites the same value.
            ptr        <= wrap_add(win, 1);
`ifdef FIFO_ARB_BURST_EN
            burst_cnt  <= cnt_nxt;
`endif
          end else begin
            fifo_winc <= 1'b0;
            ack       <= '0;
          end
        end
        default: begin
          // Forced idle cycle lets fifo_full catch up with the beat just written.
          state     <= IDLE;
          fifo_winc <= 1'b0;
          ack       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter; build with FIFO_ARB_BURST_EN to exercise bursts.
module tb_fifo_wr_arbiter;

  localparam int DSIZE     = 4;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 2;

`ifdef FIFO_ARB_BURST_EN
  localparam int FULL_NEXT = 0;
`else
  localparam int FULL_NEXT = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic [NREQ-1:0]       ack;
  logic                  fifo_full = 1'b0;
  logic                  fifo_winc;
  logic [DSIZE-1:0]      fifo_wdata;
  logic [1:0]            gnt_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DSIZE    (DSIZE),
    .NREQ     (NREQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_winc (fifo_winc),
    .fifo_wdata(fifo_wdata),
    .gnt_id    (gnt_id)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({fifo_winc, ack, gnt_id, fifo_wdata} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: winc=%b ack=%b gnt=%0d wdata=%h, want all zero", fifo_winc, ack, gnt_id, fifo_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_winc !== 1'b0 || ack !== 4'b0) begin
      errors++;
      $display("FAIL idle_no_req: winc=%b ack=%b, want 0/0000", fifo_winc, ack);
    end
  endtask

  task automatic test_single();
    req = 4'b0010;
    req_data = 16'h00A0;
    @(negedge clk);
    checks++;
    if ({fifo_winc, ack, gnt_id, fifo_wdata} !== {1'b1, 4'b0010, 2'd1, 4'hA}) begin
      errors++;
      $display("FAIL single_grant: winc=%b ack=%b gnt=%0d wdata=%h, want 1 0010 1 a", fifo_winc, ack, gnt_id, fifo_wdata);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({fifo_winc, ack, gnt_id, fifo_wdata} !== {1'b0, 4'b0000, 2'd1, 4'hA}) begin
      errors++;
      $display("FAIL single_release: winc=%b ack=%b gnt=%0d wdata=%h, want 0 0000 1 a", fifo_winc, ack, gnt_id, fifo_wdata);
    end
  endtask

  // Run all producers continuously and check the grant order against exp.
  task automatic run_seq(input string name, input int exp[], input int drop_step, input int drop_id);
    for (int i = 0; i < exp.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({fifo_winc, ack, gnt_id, fifo_wdata} !== {1'b1, 4'(1 << exp[i]), 2'(exp[i]), 4'(exp[i] + 1)}) begin
        errors++;
        $display("FAIL %s beat %0d: winc=%b ack=%b gnt=%0d wdata=%h, want gnt %0d", name, i, fifo_winc, ack, gnt_id, fifo_wdata, exp[i]);
      end
      if (i == drop_step) req[drop_id] = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_winc !== 1'b0) begin
        errors++;
        $display("FAIL %s gap %0d: winc=%b, want 0", name, i, fifo_winc);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst();
    int seq_a[] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int seq_b[] = '{0, 0, 1, 2, 2};
    do_reset();
    req_data = 16'h4321;
    req = 4'b1111;
    run_seq("burst_all", seq_a, -1, 0);
    do_reset();
    req = 4'b1111;
    run_seq("burst_drop", seq_b, 2, 1);
  endtask
`else
  task automatic test_round_robin();
    int seq[] = '{0, 1, 2, 3, 0};
    do_reset();
    req_data = 16'h4321;
    req = 4'b1111;
    run_seq("round_robin", seq, -1, 0);
  endtask
`endif

  task automatic test_full();
    do_reset();
    req_data = 16'h4321;
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (fifo_winc !== 1'b1 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL full_first: winc=%b gnt=%0d, want 1 0", fifo_winc, gnt_id);
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_winc !== 1'b0 || ack !== 4'b0) begin
        errors++;
        $display("FAIL full_blocked cycle %0d: winc=%b ack=%b, want 0 0000", i, fifo_winc, ack);
      end
    end
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if ({fifo_winc, ack, gnt_id} !== {1'b1, 4'(1 << FULL_NEXT), 2'(FULL_NEXT)}) begin
      errors++;
      $display("FAIL full_release: winc=%b ack=%b gnt=%0d, want 1 gnt %0d", fifo_winc, ack, gnt_id, FULL_NEXT);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_drop_unserved();
    do_reset();
    req_data = 16'h0650;
    req = 4'b0110;
    @(negedge clk);
    checks++;
    if ({fifo_winc, ack, gnt_id, fifo_wdata} !== {1'b1, 4'b0010, 2'd1, 4'h5}) begin
      errors++;
      $display("FAIL drop_first: winc=%b ack=%b gnt=%0d wdata=%h, want 1 0010 1 5", fifo_winc, ack, gnt_id, fifo_wdata);
    end
    req = '0;
    @(negedge clk);
    req_data = 16'h9000;
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if ({fifo_winc, ack, gnt_id, fifo_wdata} !== {1'b1, 4'b1000, 2'd3, 4'h9}) begin
      errors++;
      $display("FAIL drop_skip: winc=%b ack=%b gnt=%0d wdata=%h, want 1 1000 3 9", fifo_winc, ack, gnt_id, fifo_wdata);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_data = 16'h4321;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_winc !== 1'b1) begin
      errors++;
      $display("FAIL midrst_second_beat: winc=%b, want 1", fifo_winc);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({fifo_winc, ack, gnt_id, fifo_wdata} !== 11'b0) begin
      errors++;
      $display("FAIL midrst_clear: winc=%b ack=%b gnt=%0d wdata=%h, want all zero", fifo_winc, ack, gnt_id, fifo_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({fifo_winc, ack, gnt_id, fifo_wdata} !== {1'b1, 4'b0001, 2'd0, 4'h1}) begin
      errors++;
      $display("FAIL midrst_restart: winc=%b ack=%b gnt=%0d wdata=%h, want 1 0001 0 1", fifo_winc, ack, gnt_id, fifo_wdata);
    end
    req = '0;
    @(negedge clk);
  endtask

  // Three producers stream 8 words each into a depth-8 fifo model drained every third cycle.
  task automatic test_stream();
    int q[$];
    int sent[3];
    int rd_exp[3];
    int nread;
    int e;
    nread = 0;
    for (int k = 0; k < 3; k++) begin
      sent[k] = 0;
      rd_exp[k] = 0;
    end
    do_reset();
    req_data = '0;
    req = 4'b0111;
    for (int cyc = 0; cyc < 600 && nread < 24; cyc++) begin
      @(negedge clk);
      if (fifo_winc) begin
        checks++;
        if (q.size() >= 8 || gnt_id > 2'd2 || ack !== 4'(1 << gnt_id) || fifo_wdata !== 4'(sent[gnt_id % 3])) begin
          errors++;
          $display("FAIL stream_write: fill=%0d gnt=%0d ack=%b wdata=%h", q.size(), gnt_id, ack, fifo_wdata);
        end
        q.push_back(int'(gnt_id) * 16 + int'(fifo_wdata));
        sent[gnt_id % 3]++;
      end
      if (cyc % 3 == 0 && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (e % 16 != rd_exp[e / 16]) begin
          errors++;
          $display("FAIL stream_order: producer %0d read %0d, want %0d", e / 16, e % 16, rd_exp[e / 16]);
        end
        rd_exp[e / 16]++;
        nread++;
      end
      fifo_full = (q.size() >= 8);
      for (int k = 0; k < 3; k++) begin
        req[k] = (sent[k] < 8);
        req_data[k*DSIZE +: DSIZE] = 4'(sent[k]);
      end
    end
    checks++;
    if (nread != 24 || q.size() != 0) begin
      errors++;
      $display("FAIL stream_total: read %0d left %0d, want 24 0", nread, q.size());
    end
    req = '0;
    fifo_full = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`else
    test_round_robin();
`endif
    test_full();
    test_drop_unserved();
    test_mid_reset();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
